// File: rtl/sipo_collect.sv
// sipo_collect: serial-in parallel-out word collector.
//
// Accepts m-bit words over a valid/ready handshake and assembles n/m of them
// into one n-bit block, MSB-first: the first word accepted lands in
// out_data[n-1:n-m] and the last word in out_data[m-1:0]. The complete block is
// offered downstream over a second valid/ready handshake.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   clr        synchronous clear, discards any partial or complete block
//   in_valid   in_data holds a word
//   in_ready   collector can take a word this cycle (only combinational output)
//   in_data    input word, m bits
//   out_valid  out_data holds a complete block
//   out_ready  consumer takes the block this cycle
//   out_data   assembled block, n bits
//   count      number of words currently held, 0..n/m
//   ovf        (only with SIPO_COLLECT_OVF_EN) sticky flag: the source changed
//              in_data after being stalled, cleared by rst or clr
//
// Optional feature macro: SIPO_COLLECT_OVF_EN

module sipo_collect #(
  parameter int n = 1344,
  parameter int m = 64
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        clr,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [m-1:0]                in_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [n-1:0]                out_data,
  output logic [$clog2(n/m+1)-1:0]    count
`ifdef SIPO_COLLECT_OVF_EN
  ,
  output logic                        ovf
`endif
);

  localparam int W   = n / m;
  localparam int CW  = $clog2(W + 1);
  localparam bit ONE = (W == 1);

  typedef enum logic {
    COLLECT,
    FULL
  } state_t;

  state_t          state;
  logic [n-1:0]    sreg;
  logic [n-1:0]    shifted;
  logic [CW-1:0]   cnt;
  logic            accept;
  logic            consume;

  generate
    if (n % m != 0) begin : g_bad_width
      $error("sipo_collect: n (%0d) must be an integer multiple of m (%0d)", n, m);
    end

    // With a single word per block there is nothing to shift; the slice
    // below would be empty, so it is only elaborated for W > 1.
    if (W == 1) begin : g_one_word
      assign shifted = in_data;
    end else begin : g_multi_word
      assign shifted = {sreg[n-m-1:0], in_data};
    end
  endgenerate

  // In FULL the input is only free when the block leaves on this same edge.
  assign in_ready = (state == COLLECT) | out_ready;
  assign accept   = in_valid & in_ready;
  assign consume  = out_valid & out_ready;

  assign out_data = sreg;
  assign count    = cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= COLLECT;
      out_valid <= 1'b0;
      sreg      <= '0;
      cnt       <= '0;
    end else if (clr) begin
      state     <= COLLECT;
      out_valid <= 1'b0;
      sreg      <= '0;
      cnt       <= '0;
    end else begin
      if (accept) begin
        sreg <= shifted;
      end
      case (state)
        COLLECT: begin
          if (accept) begin
            cnt <= cnt + 1'b1;
            if (cnt == CW'(W - 1)) begin
              state     <= FULL;
              out_valid <= 1'b1;
            end
          end
        end
        FULL: begin
          if (consume) begin
            if (accept) begin
              // Old block leaves while the first word of the next one
              // arrives; a one-word block is immediately full again.
              cnt <= CW'(1);
              if (ONE) begin
                state     <= FULL;
                out_valid <= 1'b1;
              end else begin
                state     <= COLLECT;
                out_valid <= 1'b0;
              end
            end else begin
              cnt       <= '0;
              state     <= COLLECT;
              out_valid <= 1'b0;
            end
          end
        end
        default: begin
          state     <= COLLECT;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

`ifdef SIPO_COLLECT_OVF_EN
  // A stalled source must hold its word; remember the stalled word and flag
  // any change seen on the following cycle while valid is still asserted.
  logic          stall_q;
  logic [m-1:0]  data_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf     <= 1'b0;
      stall_q <= 1'b0;
      data_q  <= '0;
    end else if (clr) begin
      ovf     <= 1'b0;
      stall_q <= 1'b0;
      data_q  <= in_data;
    end else begin
      if (stall_q && in_valid && (in_data != data_q)) begin
        ovf <= 1'b1;
      end
      stall_q <= in_valid & ~in_ready;
      data_q  <= in_data;
    end
  end
`endif

endmodule

// File: tb/tb_sipo_collect.sv
// Testbench for sipo_collect: three instances (21-, 4- and 1-word blocks)
// share one stimulus stream; a word-list model predicts every output.
module tb_sipo_collect;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clr = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [63:0] in_data = '0;

  always #5 clk = ~clk;

  logic          ir0, ov0;
  logic [1343:0] od0;
  logic [4:0]    c0;
  logic          ir1, ov1;
  logic [255:0]  od1;
  logic [2:0]    c1;
  logic          ir2, ov2;
  logic [63:0]   od2;
  logic [0:0]    c2;
`ifdef SIPO_COLLECT_OVF_EN
  logic          of0, of1, of2;
`endif

  sipo_collect #(.n(1344), .m(64)) d0 (
    .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_ready(ir0),
    .in_data(in_data), .out_valid(ov0), .out_ready(out_ready),
    .out_data(od0), .count(c0)
`ifdef SIPO_COLLECT_OVF_EN
    , .ovf(of0)
`endif
  );

  sipo_collect #(.n(256), .m(64)) d1 (
    .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_ready(ir1),
    .in_data(in_data), .out_valid(ov1), .out_ready(out_ready),
    .out_data(od1), .count(c1)
`ifdef SIPO_COLLECT_OVF_EN
    , .ovf(of1)
`endif
  );

  sipo_collect #(.n(64), .m(64)) d2 (
    .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_ready(ir2),
    .in_data(in_data), .out_valid(ov2), .out_ready(out_ready),
    .out_data(od2), .count(c2)
`ifdef SIPO_COLLECT_OVF_EN
    , .ovf(of2)
`endif
  );

  // Uniform views of the three instances.
  logic          a_rdy  [3];
  logic          a_v    [3];
  int            a_cnt  [3];
  logic [1343:0] a_data [3];
  assign a_rdy[0]  = ir0;
  assign a_rdy[1]  = ir1;
  assign a_rdy[2]  = ir2;
  assign a_v[0]    = ov0;
  assign a_v[1]    = ov1;
  assign a_v[2]    = ov2;
  assign a_cnt[0]  = int'(c0);
  assign a_cnt[1]  = int'(c1);
  assign a_cnt[2]  = int'(c2);
  assign a_data[0] = od0;
  assign a_data[1] = 1344'(od1);
  assign a_data[2] = 1344'(od2);
`ifdef SIPO_COLLECT_OVF_EN
  logic a_ovf [3];
  assign a_ovf[0] = of0;
  assign a_ovf[1] = of1;
  assign a_ovf[2] = of2;
`endif

  localparam int NW [3] = '{21, 4, 1};

  // Model: words held, whether a full block is on offer, the last NW words as
  // one value, plus the stall/change history for the overflow flag.
  bit            mfull [3];
  int            mcnt  [3];
  logic [1343:0] mblk  [3];
  bit            movf  [3];
  bit            mpst  [3];
  logic [63:0]   mpd   [3];

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [1343:0] keep_mask(input int i);
    logic [1343:0] all1;
    all1 = '1;
    return all1 >> (1344 - 64 * NW[i]);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      mfull[i] = 1'b0;
      mcnt[i]  = 0;
      mblk[i]  = '0;
      movf[i]  = 1'b0;
      mpst[i]  = 1'b0;
      mpd[i]   = '0;
    end
  endtask

  // Applies one clock edge's worth of the transfer rules.
  task automatic model_edge();
    if (rst) return;
    for (int i = 0; i < 3; i++) begin
      bit rdy;
      rdy = !mfull[i] || out_ready;
      if (clr) begin
        mfull[i] = 1'b0;
        mcnt[i]  = 0;
        mblk[i]  = '0;
        movf[i]  = 1'b0;
        mpst[i]  = 1'b0;
      end else begin
        if (mpst[i] && in_valid && (in_data != mpd[i])) movf[i] = 1'b1;
        mpst[i] = in_valid && !rdy;
        mpd[i]  = in_data;
        if (mfull[i] && out_ready) begin
          mfull[i] = 1'b0;
          mcnt[i]  = 0;
        end
        if (in_valid && rdy) begin
          mblk[i] = ((mblk[i] << 64) | 1344'(in_data)) & keep_mask(i);
          mcnt[i]++;
          if (mcnt[i] == NW[i]) mfull[i] = 1'b1;
        end
      end
    end
  endtask

  // Compare process: every falling edge, all instances against the model.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("in_ready[%0d]", i), 64'(a_rdy[i]), 64'(!mfull[i] || out_ready));
      chk($sformatf("out_valid[%0d]", i), 64'(a_v[i]), 64'(mfull[i]));
      chk($sformatf("count[%0d]", i), 64'(a_cnt[i]), 64'(mcnt[i]));
      if (mfull[i]) begin
        for (int k = 0; k < NW[i]; k++) begin
          chk($sformatf("out_data[%0d].word%0d", i, k),
              64'(a_data[i] >> (64 * k)), 64'(mblk[i] >> (64 * k)));
        end
      end
`ifdef SIPO_COLLECT_OVF_EN
      chk($sformatf("ovf[%0d]", i), 64'(a_ovf[i]), 64'(movf[i]));
`endif
    end
  end

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  function automatic logic [63:0] wd0(input int k);
    return 64'(od0 >> (64 * k));
  endfunction

  initial begin
    model_reset();
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    chk("reset out_valid", 64'(ov0), 64'd0);
    chk("reset count", 64'(c0), 64'd0);
    chk("reset in_ready", 64'(ir0), 64'd1);
    chk("reset out_data", 64'(|od0), 64'd0);

    // Fill with words 1..21 while the consumer stalls.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int w = 1; w <= 21; w++) begin
      in_data = 64'(w);
      tick();
      if (w == 1) begin
        chk("w1 out_valid", 64'(ov2), 64'd1);
        chk("w1 out_data", od2, 64'd1);
      end
      if (w == 4) begin
        chk("w4 out_valid", 64'(ov1), 64'd1);
        chk("w4 top", 64'(od1 >> 192), 64'd1);
        chk("w4 bottom", 64'(od1), 64'd4);
      end
      if (w == 20) chk("fill not yet valid", 64'(ov0), 64'd0);
    end
    chk("fill out_valid", 64'(ov0), 64'd1);
    chk("fill top", wd0(20), 64'd1);
    chk("fill bottom", wd0(0), 64'h15);
    chk("fill count", 64'(c0), 64'd21);
    chk("fill in_ready", 64'(ir0), 64'd0);

    // Stall with the word held.
    in_data = 64'd22;
    repeat (10) tick();
    chk("stall count", 64'(c0), 64'd21);
    chk("stall top", wd0(20), 64'd1);
    chk("stall bottom", wd0(0), 64'h15);
    chk("stall out_valid", 64'(ov0), 64'd1);
`ifdef SIPO_COLLECT_OVF_EN
    chk("stall ovf clean", 64'(of0), 64'd0);
`endif

    // Back-to-back blocks at one word per cycle.
    out_ready = 1'b1;
    for (int k = 0; k < 42; k++) begin
      in_data = 64'(22 + k);
      tick();
      chk("b2b count", 64'(c0), 64'((k % 21) + 1));
      if (k == 20 || k == 41) chk("b2b out_valid", 64'(ov0), 64'd1);
      if (k == 21) chk("b2b valid drops", 64'(ov0), 64'd0);
      if (k == 20) chk("b2b second top", wd0(20), 64'd22);
      if (k == 41) begin
        chk("b2b third top", wd0(20), 64'd43);
        chk("b2b third bottom", wd0(0), 64'd63);
      end
    end

    // Drain, then clear part-way through a block.
    in_valid = 1'b0;
    tick();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int w = 0; w < 7; w++) begin
      in_data = 64'(100 + w);
      tick();
    end
    chk("pre-clr count", 64'(c0), 64'd7);
    clr     = 1'b1;
    in_data = 64'd107;
    tick();
    clr = 1'b0;
    chk("clr count", 64'(c0), 64'd0);
    chk("clr out_valid", 64'(ov0), 64'd0);
    for (int w = 0; w < 21; w++) begin
      in_data = 64'(200 + w);
      tick();
    end
    chk("post-clr out_valid", 64'(ov0), 64'd1);
    chk("post-clr top", wd0(20), 64'd200);
    chk("post-clr bottom", wd0(0), 64'd220);

    // Asynchronous reset between edges while full.
    in_valid = 1'b0;
    @(posedge clk);
    model_edge();
    #3;
    rst = 1'b1;
    model_reset();
    #1;
    chk("async rst out_valid", 64'(ov0), 64'd0);
    chk("async rst count", 64'(c0), 64'd0);
    chk("async rst out_data", 64'(|od0), 64'd0);
    tick();
    rst = 1'b0;

`ifdef SIPO_COLLECT_OVF_EN
    in_valid = 1'b1;
    for (int w = 0; w < 21; w++) begin
      in_data = 64'(300 + w);
      tick();
    end
    in_data = 64'd500;
    tick();
    chk("ovf before change", 64'(of0), 64'd0);
    in_data = 64'd501;
    tick();
    chk("ovf after change", 64'(of0), 64'd1);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("ovf cleared", 64'(of0), 64'd0);
`endif

    // Randomised traffic, including occasional clears.
    for (int c = 0; c < 3000; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      clr       = ($urandom_range(0, 60) == 0);
      if ($urandom_range(0, 3) != 0) in_data = {$urandom, $urandom};
      tick();
    end
    clr      = 1'b0;
    in_valid = 1'b0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
